// File: rtl/shift_issue_stage.sv
// Shift issue stage: decodes MIPS SPECIAL shift instructions into barrel-shifter
// operands and holds them in a 2-entry skid buffer with valid/ready on both sides.
module shift_issue_stage #(
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [31:0]        instr,
  input  logic [31:0]        rs_value,
  input  logic [31:0]        rt_value,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        value,
  output logic [4:0]         shift_amount,
  output logic [1:0]         shift_func,
  output logic [4:0]         dest_reg,
  output logic [COUNT_W-1:0] dropped_count
);

  localparam logic [1:0] SHIFT_NOTHING        = 2'b00;
  localparam logic [1:0] SHIFT_LEFT_UNSIGNED  = 2'b01;
  localparam logic [1:0] SHIFT_RIGHT_UNSIGNED = 2'b10;
  localparam logic [1:0] SHIFT_RIGHT_SIGNED   = 2'b11;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] FN_SLL     = 6'b000000;
  localparam logic [5:0] FN_SRL     = 6'b000010;
  localparam logic [5:0] FN_SRA     = 6'b000011;
  localparam logic [5:0] FN_SLLV    = 6'b000100;
  localparam logic [5:0] FN_SRLV    = 6'b000110;
  localparam logic [5:0] FN_SRAV    = 6'b000111;

  typedef struct packed {
    logic [31:0] value;
    logic [4:0]  amt;
    logic [1:0]  func;
    logic [4:0]  dest;
  } entry_t;

  entry_t             head_q, head_d;
  entry_t             tail_q, tail_d;
  logic [1:0]         count_q, count_d;
  logic [COUNT_W-1:0] dropped_q, dropped_d;

  logic       decShift;
  logic [4:0] decAmt;
  logic [1:0] decFunc;
  entry_t     newEntry;
  logic       accept;
  logic       keep;
  logic       push;
  logic       pop;
  logic       dropEn;

  always_comb begin
    decShift = 1'b0;
    decAmt   = 5'd0;
    decFunc  = SHIFT_NOTHING;
    if (instr[31:26] == OP_SPECIAL) begin
      unique case (instr[5:0])
        FN_SLL: begin
          decShift = 1'b1;
          decAmt   = instr[10:6];
          decFunc  = SHIFT_LEFT_UNSIGNED;
        end
        FN_SRL: begin
          decShift = 1'b1;
          decAmt   = instr[10:6];
          decFunc  = SHIFT_RIGHT_UNSIGNED;
        end
        FN_SRA: begin
          decShift = 1'b1;
          decAmt   = instr[10:6];
          decFunc  = SHIFT_RIGHT_SIGNED;
        end
        FN_SLLV: begin
          decShift = 1'b1;
          decAmt   = rs_value[4:0];
          decFunc  = SHIFT_LEFT_UNSIGNED;
        end
        FN_SRLV: begin
          decShift = 1'b1;
          decAmt   = rs_value[4:0];
          decFunc  = SHIFT_RIGHT_UNSIGNED;
        end
        FN_SRAV: begin
          decShift = 1'b1;
          decAmt   = rs_value[4:0];
          decFunc  = SHIFT_RIGHT_SIGNED;
        end
        default: begin
          decShift = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    newEntry.value = rt_value;
    newEntry.amt   = decAmt;
    newEntry.func  = decFunc;
    newEntry.dest  = instr[15:11];
  end

  // Readiness depends only on registered occupancy so it never loops back through out_ready.
  assign in_ready  = !rst && (count_q < 2'd2);
  assign out_valid = (count_q != 2'd0);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign keep      = decShift && (instr[15:11] != 5'd0);
  assign push      = accept && keep && !flush;
  assign dropEn    = accept && !keep && !flush;

  always_comb begin
    count_d   = count_q;
    head_d    = head_q;
    tail_d    = tail_q;
    dropped_d = dropped_q;
    if (flush) begin
      count_d = 2'd0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count_q == 2'd0) begin
            head_d = newEntry;
          end else begin
            tail_d = newEntry;
          end
          count_d = count_q + 2'd1;
        end
        2'b01: begin
          if (count_q == 2'd2) begin
            head_d = tail_q;
          end
          count_d = count_q - 2'd1;
        end
        2'b11: begin
          if (count_q == 2'd1) begin
            head_d = newEntry;
          end else begin
            head_d = tail_q;
            tail_d = newEntry;
          end
        end
        default: begin
          count_d = count_q;
        end
      endcase
      if (dropEn && (dropped_q != {COUNT_W{1'b1}})) begin
        dropped_d = dropped_q + COUNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q   <= 2'd0;
      head_q    <= '0;
      tail_q    <= '0;
      dropped_q <= '0;
    end else begin
      count_q   <= count_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      dropped_q <= dropped_d;
    end
  end

  assign value         = head_q.value;
  assign shift_amount  = head_q.amt;
  assign shift_func    = head_q.func;
  assign dest_reg      = head_q.dest;
  assign dropped_count = dropped_q;

endmodule

// File: doc/shift_issue_stage.md
Name: shift_issue_stage

Overview:
- Pipeline stage directly upstream of the MIPS barrel shifter. Decodes SPECIAL-opcode shift instructions (SLL/SRL/SRA/SLLV/SRLV/SRAV) into the shifter's value / shift_amount / shift_func operands.
- Registers decoded operands in a 2-entry skid buffer with valid/ready handshakes on both sides.
- Non-shift instructions and shifts to $zero are consumed and dropped, and counted.

Parameters:
- COUNT_W, 16, width of the saturating dropped-instruction counter.

Ports:
- clk  input  1  single clock, rising edge
- rst  input  1  synchronous active-high reset
- flush  input  1  discard all buffered entries and the current input
- in_valid  input  1  upstream has an instruction
- in_ready  output  1  stage accepts this cycle
- instr  input  32  instruction word
- rs_value  input  32  register-file rs read data
- rt_value  input  32  register-file rt read data
- out_valid  output  1  head entry valid
- out_ready  input  1  downstream consumes head
- value  output  32  operand to shift (rt_value of head)
- shift_amount  output  5  shamt or rs_value[4:0]
- shift_func  output  2  `SHIFT_* code for the shifter
- dest_reg  output  5  rd field of head
- dropped_count  output  COUNT_W  saturating count of dropped instructions

Behaviour:
- Clock and reset: one clock (clk); rst is synchronous and active-high, sampled on the rising edge of clk.
- Reset:
  - Buffer count = 0; out_valid = 0.
  - value, shift_amount, shift_func, dest_reg = 0 (shift_func = `SHIFT_NOTHING = 2'b00).
  - dropped_count = 0.
  - in_ready = 0 while rst is high.
- Decode, combinational on instr. Applies only when opcode instr[31:26] == 6'b000000.
  - funct 000000 SLL: amt = instr[10:6], func = `SHIFT_LEFT_UNSIGNED (01).
  - funct 000010 SRL: amt = instr[10:6], func = `SHIFT_RIGHT_UNSIGNED (10).
  - funct 000011 SRA: amt = instr[10:6], func = `SHIFT_RIGHT_SIGNED (11).
  - funct 000100 SLLV / 000110 SRLV / 000111 SRAV: amt = rs_value[4:0], func as the fixed-amount form. Upper rs bits are ignored.
  - value = rt_value; dest = instr[15:11].
  - Any other opcode or funct is a non-shift.
- Drop rule:
  - An accepted instruction that is a non-shift, or a shift with rd == 0 (this includes NOP 0x00000000), is consumed and not enqueued.
  - dropped_count increments by 1 per dropped instruction and saturates at all-ones.
- Handshake:
  - Accept when in_valid && in_ready. in_ready = !rst && (count < 2), combinational from registered count only, never from out_ready.
  - Pop when out_valid && out_ready. out_valid = (count != 0).
  - Outputs are always the head entry, driven directly from registers.
  - Operands are captured at accept; later changes of rs_value/rt_value do not affect buffered entries.
- Buffer:
  - 2 entries, FIFO order, each holding {value, amt, func, dest}.
  - Push only: count+1. Pop only: count-1, second entry moves to head.
  - Push and pop in the same cycle with count = 1: the new entry becomes head and count stays 1.
  - Push and pop with count = 0 cannot occur: out_valid = 0.
  - A dropped instruction never changes count but still consumes its handshake.
- Latency: an enqueued instruction appears on out_valid the cycle after acceptance, earliest. Throughput is 1 per cycle with out_ready held high.
- Flush:
  - count <- 0 and out_valid = 0 next cycle.
  - The input presented in the flush cycle is not enqueued and not counted, even if in_valid && in_ready.
  - Head register contents are don't-care after a flush; output fields are held until the next enqueue.
- Priority: rst > flush > normal operation.
- Reset mid-transfer: buffered entries are lost and dropped_count is cleared.
- With out_valid high and out_ready low, all outputs must remain stable.

Test Plan:
- Fixed-amount shift:
  - Stimulus: after reset, instr = 0x00041080 (SLL $2,$4,2), rt_value = 0x0000_0003, out_ready = 1.
  - Required: next cycle out_valid = 1, value = 0x3, shift_amount = 2, shift_func = 01, dest_reg = 2.
- Variable shift:
  - Stimulus: instr = 0x00A41807 (SRAV $3,$4,$5), rs_value = 0xFFFF_FFE4, rt_value = 0x8000_0000.
  - Required: shift_amount = 4, shift_func = 11, dest_reg = 3, value = 0x8000_0000.
- Drops:
  - Stimulus: issue 0x00000000 (NOP), then 0x8C020000 (LW), then 0x00021042 (SRL $2,$2,1).
  - Required: only the SRL is emitted (shift_func = 10, amt = 1); dropped_count = 2.
- Backpressure:
  - Stimulus: out_ready = 0, three valid shifts presented back-to-back.
  - Required: first two accepted, in_ready = 0 on the third cycle, outputs stable.
  - Then raise out_ready: entries drain in order and the third is accepted once count drops below 2.
- Simultaneous push/pop and flush:
  - Stimulus: count = 1, push and pop in one cycle.
  - Required: count stays 1 and the new entry is at head.
  - Stimulus: assert flush with count = 2 and in_valid = 1.
  - Required: next cycle out_valid = 0, count = 0, dropped_count unchanged.
- Reset and saturation:
  - Stimulus: rst asserted mid-stream with 2 entries buffered.
  - Required: out_valid = 0, outputs zero, dropped_count = 0, in_ready = 0 during reset and 1 after.
  - Stimulus: with COUNT_W = 2, drop 5 instructions.
  - Required: dropped_count = 3.
